// File: rtl/enemy_ctrl.sv
// enemy_ctrl: per-enemy behaviour controller sitting between collision/physics
// and the sprite renderer. MODE 0 is a walker that squashes when stomped,
// MODE 1 is a shell enemy that retreats into a kickable, sliding shell.
// All outputs are registered: an input pulse in cycle N shows up in cycle N+1.
// Optional macro ENEMY_ANIM_EN adds a two-frame walk animation; without it the
// walk sprite is static and no frame counter exists.
module enemy_ctrl #(
    parameter int          MODE         = 0,
    parameter int          SQUASH_TICKS = 50000000,
    parameter int          WAKE_TICKS   = 250000000,
    parameter int          ANIM_TICKS   = 12500000,
    parameter logic [5:0]  ID_WALK      = 6'd10,
    parameter logic [5:0]  ID_SQUASH    = 6'd12,
    parameter logic [5:0]  ID_SHELL     = 6'd14,
    parameter logic [5:0]  ID_NONE      = 6'd63
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       spawn,
    input  logic       despawn,
    input  logic       bump,
    input  logic       stomp,
    input  logic       kick,
    input  logic       kick_dir,
    output logic [5:0] id,
    output logic       oriental,
    output logic       moving,
    output logic       fast,
    output logic       live,
    output logic       showing,
    output logic       score_pulse
);

    // Timer width covers the largest tick count any counter has to reach.
    localparam int MAX_AB = (SQUASH_TICKS > WAKE_TICKS) ? SQUASH_TICKS : WAKE_TICKS;
    localparam int MAX_T  = (MAX_AB > ANIM_TICKS) ? MAX_AB : ANIM_TICKS;
    localparam int TW     = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {
        HIDDEN   = 3'd0,
        WALK     = 3'd1,
        SQUASHED = 3'd2,
        SHELL    = 3'd3,
        SLIDE    = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nx;
    logic            orient_nx;
    logic            score_nx;
    logic [5:0]      walk_id;

`ifdef ENEMY_ANIM_EN
    logic [TW-1:0]   anim_cnt;
    logic [TW-1:0]   anim_nx;
    logic            frame;
    logic            frame_nx;
`endif

    // Counting up stops at all-ones so a long stay can never wrap back to zero.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
        return (&t) ? t : t + 1'b1;
    endfunction

    // Next-state decision: despawn beats everything, then stomp, kick, bump,
    // and at most one of them is acted on in a cycle.
    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        orient_nx = oriental;
        score_nx  = 1'b0;
        if (state != HIDDEN && despawn) begin
            state_nx = HIDDEN;
            timer_nx = '0;
        end else begin
            case (state)
                HIDDEN: begin
                    if (spawn) begin
                        state_nx  = WALK;
                        orient_nx = 1'b1;
                        timer_nx  = '0;
                    end
                end
                WALK: begin
                    if (stomp) begin
                        state_nx = (MODE == 1) ? SHELL : SQUASHED;
                        timer_nx = '0;
                        score_nx = 1'b1;
                    end else if (bump) begin
                        orient_nx = ~oriental;
                    end
                end
                SQUASHED: begin
                    if (timer == TW'(SQUASH_TICKS - 1)) begin
                        state_nx = HIDDEN;
                        timer_nx = '0;
                    end else begin
                        timer_nx = sat_inc(timer);
                    end
                end
                SHELL: begin
                    if (stomp) begin
                        timer_nx = '0;
                    end else if (kick) begin
                        state_nx  = SLIDE;
                        orient_nx = kick_dir;
                        timer_nx  = '0;
                    end else if (timer == TW'(WAKE_TICKS - 1)) begin
                        state_nx = WALK;
                        timer_nx = '0;
                    end else begin
                        timer_nx = sat_inc(timer);
                    end
                end
                SLIDE: begin
                    if (stomp) begin
                        state_nx = SHELL;
                        timer_nx = '0;
                        score_nx = 1'b1;
                    end else if (bump) begin
                        orient_nx = ~oriental;
                    end
                end
                default: begin
                    state_nx = HIDDEN;
                    timer_nx = '0;
                end
            endcase
        end
    end

`ifdef ENEMY_ANIM_EN
    // Walk animation: the frame flips every ANIM_TICKS cycles spent in WALK and
    // restarts at frame 0 whenever WALK is entered afresh.
    always_comb begin
        anim_nx  = '0;
        frame_nx = 1'b0;
        if (state == WALK && state_nx == WALK) begin
            if (anim_cnt == TW'(ANIM_TICKS - 1)) begin
                anim_nx  = '0;
                frame_nx = ~frame;
            end else begin
                anim_nx  = anim_cnt + 1'b1;
                frame_nx = frame;
            end
        end
        walk_id = frame_nx ? (ID_WALK + 6'd1) : ID_WALK;
    end
`else
    // Without animation the walk sprite never changes.
    always_comb begin
        walk_id = ID_WALK;
    end
`endif

    // State, timer and all outputs are registered from the next-state decision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= HIDDEN;
            timer       <= '0;
            id          <= ID_NONE;
            oriental    <= 1'b1;
            moving      <= 1'b0;
            fast        <= 1'b0;
            live        <= 1'b0;
            showing     <= 1'b0;
            score_pulse <= 1'b0;
`ifdef ENEMY_ANIM_EN
            anim_cnt    <= '0;
            frame       <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            oriental    <= orient_nx;
            score_pulse <= score_nx;
`ifdef ENEMY_ANIM_EN
            anim_cnt    <= anim_nx;
            frame       <= frame_nx;
`endif
            case (state_nx)
                WALK: begin
                    id      <= walk_id;
                    moving  <= 1'b1;
                    fast    <= 1'b0;
                    live    <= 1'b1;
                    showing <= 1'b1;
                end
                SQUASHED: begin
                    id      <= ID_SQUASH;
                    moving  <= 1'b0;
                    fast    <= 1'b0;
                    live    <= 1'b0;
                    showing <= 1'b1;
                end
                SHELL: begin
                    id      <= ID_SHELL;
                    moving  <= 1'b0;
                    fast    <= 1'b0;
                    live    <= 1'b0;
                    showing <= 1'b1;
                end
                SLIDE: begin
                    id      <= ID_SHELL;
                    moving  <= 1'b1;
                    fast    <= 1'b1;
                    live    <= 1'b1;
                    showing <= 1'b1;
                end
                default: begin
                    id      <= ID_NONE;
                    moving  <= 1'b0;
                    fast    <= 1'b0;
                    live    <= 1'b0;
                    showing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_ctrl.sv
// tb_enemy_ctrl: two enemy_ctrl instances (walker and shell enemy, short tick
// counts) driven by directed tables, hand-written reset sequences and random
// pulses compared against a phase/age reference model.
module tb_enemy_ctrl;

    localparam int SQ = 4;
    localparam int WK = 6;
    localparam int AN = 3;

    // Input bit positions: {kick_dir, kick, stomp, bump, despawn, spawn}
    localparam logic [5:0] SP = 6'b000001;
    localparam logic [5:0] DS = 6'b000010;
    localparam logic [5:0] BU = 6'b000100;
    localparam logic [5:0] ST = 6'b001000;
    localparam logic [5:0] KI = 6'b010000;
    localparam logic [5:0] KD = 6'b100000;
    localparam logic [5:0] NO = 6'b000000;

    localparam int K_GONE  = 0;
    localparam int K_WALK  = 1;
    localparam int K_FLAT  = 2;
    localparam int K_SHELL = 3;
    localparam int K_SLIDE = 4;

    typedef struct packed {
        logic [5:0]  in;
        logic [11:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  in0;
    logic [5:0]  in1;
    logic [11:0] out0;
    logic [11:0] out1;

    int errors = 0;
    int checks = 0;

    int m_kind [2];
    int m_age  [2];
    int m_walk [2];
    bit m_face [2];
    bit m_scr  [2];

    vec_t tab0[$];
    vec_t tab1[$];

    always #5 clk = ~clk;

    enemy_ctrl #(.MODE(0), .SQUASH_TICKS(SQ), .WAKE_TICKS(WK), .ANIM_TICKS(AN)) dut0 (
        .clk(clk), .rstn(rstn),
        .spawn(in0[0]), .despawn(in0[1]), .bump(in0[2]), .stomp(in0[3]),
        .kick(in0[4]), .kick_dir(in0[5]),
        .id(out0[11:6]), .oriental(out0[5]), .moving(out0[4]), .fast(out0[3]),
        .live(out0[2]), .showing(out0[1]), .score_pulse(out0[0])
    );

    enemy_ctrl #(.MODE(1), .SQUASH_TICKS(SQ), .WAKE_TICKS(WK), .ANIM_TICKS(AN)) dut1 (
        .clk(clk), .rstn(rstn),
        .spawn(in1[0]), .despawn(in1[1]), .bump(in1[2]), .stomp(in1[3]),
        .kick(in1[4]), .kick_dir(in1[5]),
        .id(out1[11:6]), .oriental(out1[5]), .moving(out1[4]), .fast(out1[3]),
        .live(out1[2]), .showing(out1[1]), .score_pulse(out1[0])
    );

    // Output vector layout: {id, oriental, moving, fast, live, showing, score_pulse}
    function automatic logic [11:0] pk(input logic [5:0] i, input logic o, input logic m,
                                       input logic f, input logic l, input logic s,
                                       input logic p);
        return {i, o, m, f, l, s, p};
    endfunction

    function automatic logic [11:0] e_hid(input logic o);
        return pk(6'd63, o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [11:0] e_walk(input logic o);
        return pk(6'd10, o, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    endfunction
    function automatic logic [11:0] e_flat(input logic o, input logic p);
        return pk(6'd12, o, 1'b0, 1'b0, 1'b0, 1'b1, p);
    endfunction
    function automatic logic [11:0] e_shell(input logic o, input logic p);
        return pk(6'd14, o, 1'b0, 1'b0, 1'b0, 1'b1, p);
    endfunction
    function automatic logic [11:0] e_slide(input logic o);
        return pk(6'd14, o, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    endfunction

    task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b);
        in0 = a;
        in1 = b;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got id=%0d flags=%b, expected id=%0d flags=%b",
                     name, act[11:6], act[5:0], exp[11:6], exp[5:0]);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_kind[d] = K_GONE;
            m_age[d]  = 0;
            m_walk[d] = 0;
            m_face[d] = 1'b1;
            m_scr[d]  = 1'b0;
        end
    endtask

    // Reference behaviour: phase kind plus the number of cycles spent in it.
    task automatic model_step(input int d, input int mode, input logic [5:0] v);
        m_scr[d] = 1'b0;
        if (m_kind[d] != K_GONE && v[1]) begin
            m_kind[d] = K_GONE;
            m_age[d]  = 0;
        end else begin
            case (m_kind[d])
                K_GONE: if (v[0]) begin
                    m_kind[d] = K_WALK;
                    m_face[d] = 1'b1;
                    m_walk[d] = 0;
                end
                K_WALK: if (v[3]) begin
                    m_kind[d] = (mode == 1) ? K_SHELL : K_FLAT;
                    m_age[d]  = 0;
                    m_scr[d]  = 1'b1;
                end else begin
                    if (v[2]) m_face[d] = ~m_face[d];
                    m_walk[d]++;
                end
                K_FLAT: if (m_age[d] + 1 >= SQ) begin
                    m_kind[d] = K_GONE;
                    m_age[d]  = 0;
                end else begin
                    m_age[d]++;
                end
                K_SHELL: if (v[3]) begin
                    m_age[d] = 0;
                end else if (v[4]) begin
                    m_kind[d] = K_SLIDE;
                    m_face[d] = v[5];
                    m_age[d]  = 0;
                end else if (m_age[d] + 1 >= WK) begin
                    m_kind[d] = K_WALK;
                    m_walk[d] = 0;
                    m_age[d]  = 0;
                end else begin
                    m_age[d]++;
                end
                default: if (v[3]) begin
                    m_kind[d] = K_SHELL;
                    m_age[d]  = 0;
                    m_scr[d]  = 1'b1;
                end else if (v[2]) begin
                    m_face[d] = ~m_face[d];
                end
            endcase
        end
    endtask

    function automatic logic [11:0] model_out(input int d);
        logic [5:0] wid;
        wid = 6'd10;
`ifdef ENEMY_ANIM_EN
        if (((m_walk[d] / AN) % 2) == 1) wid = 6'd11;
`endif
        case (m_kind[d])
            K_WALK:  return pk(wid, m_face[d], 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            K_FLAT:  return e_flat(m_face[d], m_scr[d]);
            K_SHELL: return e_shell(m_face[d], m_scr[d]);
            K_SLIDE: return e_slide(m_face[d]);
            default: return e_hid(m_face[d]);
        endcase
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        applyStimulus(NO, NO);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        rstn = 1'b0;
        applyStimulus(NO, NO);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset0", out0, e_hid(1'b1));
        checkOutput("reset1", out1, e_hid(1'b1));
        rstn = 1'b1;

        // Walker: spawn, bumps, bump+stomp, squash duration, ignored inputs.
        tab0.push_back('{SP,      e_walk(1'b1)});
        tab0.push_back('{NO,      e_walk(1'b1)});
        tab0.push_back('{BU,      e_walk(1'b0)});
        tab0.push_back('{NO,      e_walk(1'b0)});
        tab0.push_back('{NO,      e_walk(1'b0)});
        tab0.push_back('{BU,      e_walk(1'b1)});
        tab0.push_back('{BU | ST, e_flat(1'b1, 1'b1)});
        tab0.push_back('{NO,      e_flat(1'b1, 1'b0)});
        tab0.push_back('{ST | BU, e_flat(1'b1, 1'b0)});
        tab0.push_back('{KI,      e_flat(1'b1, 1'b0)});
        tab0.push_back('{NO,      e_hid(1'b1)});
        tab0.push_back('{ST,      e_hid(1'b1)});
        tab0.push_back('{SP | KI, e_walk(1'b1)});
        tab0.push_back('{KI | KD, e_walk(1'b1)});
        tab0.push_back('{DS | ST, e_hid(1'b1)});
        tab0.push_back('{SP | BU, e_walk(1'b1)});
        tab0.push_back('{ST | KI, e_flat(1'b1, 1'b1)});
        tab0.push_back('{DS,      e_hid(1'b1)});

        // Shell enemy: shell wake-up, kick, slide bump, re-arm, despawn vs kick.
        tab1.push_back('{SP,           e_walk(1'b1)});
        tab1.push_back('{ST,           e_shell(1'b1, 1'b1)});
        tab1.push_back('{NO,           e_shell(1'b1, 1'b0)});
        tab1.push_back('{BU,           e_shell(1'b1, 1'b0)});
        tab1.push_back('{NO,           e_shell(1'b1, 1'b0)});
        tab1.push_back('{NO,           e_shell(1'b1, 1'b0)});
        tab1.push_back('{NO,           e_shell(1'b1, 1'b0)});
        tab1.push_back('{NO,           e_walk(1'b1)});
        tab1.push_back('{ST,           e_shell(1'b1, 1'b1)});
        tab1.push_back('{KI,           e_slide(1'b0)});
        tab1.push_back('{BU,           e_slide(1'b1)});
        tab1.push_back('{KI,           e_slide(1'b1)});
        tab1.push_back('{ST,           e_shell(1'b1, 1'b1)});
        tab1.push_back('{ST | KI,      e_shell(1'b1, 1'b0)});
        tab1.push_back('{KI | KD,      e_slide(1'b1)});
        tab1.push_back('{ST | BU,      e_shell(1'b1, 1'b1)});
        tab1.push_back('{KI | DS,      e_hid(1'b1)});

`ifndef ENEMY_ANIM_EN
        for (int i = 0; i < tab0.size(); i++) begin
            applyStimulus(tab0[i].in, NO);
            @(posedge clk);
            #1;
            checkOutput($sformatf("walker_vec%0d", i), out0, tab0[i].exp);
        end
        for (int i = 0; i < tab1.size(); i++) begin
            applyStimulus(NO, tab1[i].in);
            @(posedge clk);
            #1;
            checkOutput($sformatf("shell_vec%0d", i), out1, tab1[i].exp);
        end
`else
        // Walk animation frames followed by an asynchronous reset mid-walk.
        begin
            logic [5:0] frames [7];
            frames = '{6'd10, 6'd10, 6'd10, 6'd11, 6'd11, 6'd11, 6'd10};
            for (int i = 0; i < 7; i++) begin
                applyStimulus((i == 0) ? SP : NO, NO);
                @(posedge clk);
                #1;
                checkOutput($sformatf("anim_frame%0d", i), out0,
                            pk(frames[i], 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
            end
        end
`endif

        // Asynchronous reset while both timers are running.
        do_reset();
        applyStimulus(SP, SP);
        @(posedge clk);
        #1;
        applyStimulus(ST, ST);
        @(posedge clk);
        #1;
        applyStimulus(NO, NO);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pre_async0", out0, e_flat(1'b1, 1'b0));
        checkOutput("pre_async1", out1, e_shell(1'b1, 1'b0));
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("async_rst0", out0, e_hid(1'b1));
        checkOutput("async_rst1", out1, e_hid(1'b1));
        applyStimulus(SP, SP);
        @(posedge clk);
        #1;
        checkOutput("held_rst0", out0, e_hid(1'b1));
        checkOutput("held_rst1", out1, e_hid(1'b1));
        rstn = 1'b1;
        model_reset();

        // Random pulses against the reference model for both modes.
        for (int c = 0; c < 600; c++) begin
            logic [5:0] r0;
            logic [5:0] r1;
            r0 = {$urandom_range(0, 1) == 1, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 4,  $urandom_range(0, 99) < 25};
            r1 = {$urandom_range(0, 1) == 1, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 4,  $urandom_range(0, 99) < 25};
            applyStimulus(r0, r1);
            model_step(0, 0, r0);
            model_step(1, 1, r1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("rand_walker%0d", c), out0, model_out(0));
            checkOutput($sformatf("rand_shell%0d", c), out1, model_out(1));
        end

        applyStimulus(NO, NO);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
